// File: rtl/pipe_collision_checker_pkg.sv
// Shared flappy-bird constants: FSM encodings, screen geometry and the pipe gap table.
package flappy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ARMED = 3'b010,
    ST_HIT   = 3'b100
  } state_t;

  localparam int SCREEN_H   = 480;
  localparam int SCREEN_W   = 640;
  localparam int PIPE_COUNT = 5;

  // Element 0 is the rightmost entry: gap tops for pipes 0..4 are 120, 200, 80, 260, 160.
  localparam logic [4:0][9:0] GAP_TABLE = {10'd160, 10'd260, 10'd80, 10'd200, 10'd120};

  function automatic logic [9:0] gap_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return GAP_TABLE[0];
      3'd1:    return GAP_TABLE[1];
      3'd2:    return GAP_TABLE[2];
      3'd3:    return GAP_TABLE[3];
      3'd4:    return GAP_TABLE[4];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_collision_checker_if.sv
// Bus between the pipe generator / bird logic and the collision checker.
interface pipe_collision_checker_if;
  logic       Run;
  logic       Ack;
  logic [2:0] Pipe_Idx;
  logic [9:0] X_Edge_L;
  logic [9:0] X_Edge_R;
  logic [9:0] Bird_Y;
  logic       Stop;
  logic [9:0] Gap_Top;
  logic [9:0] Gap_Bot;
  logic       Q_Idle;
  logic       Q_Armed;
  logic       Q_Hit;

  modport master (
    output Run, Ack, Pipe_Idx, X_Edge_L, X_Edge_R, Bird_Y,
    input  Stop, Gap_Top, Gap_Bot, Q_Idle, Q_Armed, Q_Hit
  );

  modport slave (
    input  Run, Ack, Pipe_Idx, X_Edge_L, X_Edge_R, Bird_Y,
    output Stop, Gap_Top, Gap_Bot, Q_Idle, Q_Armed, Q_Hit
  );
endinterface

// File: rtl/pipe_collision_checker_gap_rom.sv
// Five-entry gap ROM with a registered address; indices 5..7 read as "no pipe".
module pipe_gap_rom
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] addr,
  output logic [9:0] gap_top,
  output logic       valid
);

  logic [2:0] addr_q;

  // Reset parks on a no-pipe index so a flushed pipeline never loads a stale gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= 3'd7;
    end else begin
      addr_q <= addr;
    end
  end

  assign valid   = (addr_q < 3'(PIPE_COUNT));
  assign gap_top = gap_of(addr_q);

endmodule

// File: rtl/pipe_collision_checker.sv
// Three-stage bird/pipe collision checker driving the generator's Stop level.
module pipe_collision_checker
  import flappy_pkg::*;
#(
  parameter int BIRD_X_L = 200,
  parameter int BIRD_X_R = 230,
  parameter int BIRD_H   = 20,
  parameter int GAP_H    = 140,
  parameter int SCREEN_H = 480
) (
  input logic                     clk,
  input logic                     reset,
  pipe_collision_checker_if.slave bus
);

  localparam logic [9:0]  BIRD_LEFT  = 10'(BIRD_X_L);
  localparam logic [9:0]  BIRD_RIGHT = 10'(BIRD_X_R);
  localparam logic [10:0] BIRD_TALL  = 11'(BIRD_H);
  localparam logic [9:0]  GAP_OPEN   = 10'(GAP_H);
  localparam logic [10:0] FLOOR_Y    = 11'(SCREEN_H);

  state_t      state;
  logic        stop;
  logic        accept;
  logic        v1, v2;
  logic [9:0]  x_l1, x_r1, y1;
  logic [10:0] bird_bot1;
  logic [9:0]  rom_gap;
  logic [10:0] rom_bot;
  logic        rom_valid;
  logic [9:0]  gap_top, gap_bot;
  logic        x_overlap, y_out, idx_valid, bound;
  logic        pipe_hit, hit;

  pipe_gap_rom u_gap_rom (
    .clk     (clk),
    .reset   (reset),
    .addr    (bus.Pipe_Idx),
    .gap_top (rom_gap),
    .valid   (rom_valid)
  );

  // Data only enters the pipe while armed and counting; anything else is dropped.
  assign accept = bus.Run && (state == ST_ARMED);

  always_ff @(posedge clk) begin
    if (reset) begin
      x_l1 <= '0;
      x_r1 <= '0;
      y1   <= '0;
      v1   <= 1'b0;
    end else begin
      x_l1 <= bus.X_Edge_L;
      x_r1 <= bus.X_Edge_R;
      y1   <= bus.Bird_Y;
      v1   <= accept;
    end
  end

  assign bird_bot1 = {1'b0, y1} + BIRD_TALL;
  assign rom_bot   = {1'b0, rom_gap} + {1'b0, GAP_OPEN};

  // Gap bounds only move for a real pipe, so the renderer keeps the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_top   <= '0;
      gap_bot   <= '0;
      x_overlap <= 1'b0;
      y_out     <= 1'b0;
      idx_valid <= 1'b0;
      bound     <= 1'b0;
      v2        <= 1'b0;
    end else begin
      if (rom_valid) begin
        gap_top <= rom_gap;
        gap_bot <= rom_gap + GAP_OPEN;
      end
      idx_valid <= rom_valid;
      x_overlap <= (x_l1 <= BIRD_RIGHT) && (x_r1 >= BIRD_LEFT);
      y_out     <= (y1 < rom_gap) || (bird_bot1 > rom_bot);
      bound     <= (y1 == 10'd0) || (bird_bot1 >= FLOOR_Y);
      v2        <= accept && v1;
    end
  end

  assign pipe_hit = idx_valid && x_overlap && y_out;
  assign hit      = v2 && (pipe_hit || bound);

  // A hit beats Run falling; leaving HIT needs Ack and re-arming needs Run again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      stop  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          stop <= 1'b0;
          if (bus.Run) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (hit) begin
            state <= ST_HIT;
            stop  <= 1'b1;
          end else if (!bus.Run) begin
            state <= ST_IDLE;
            stop  <= 1'b0;
          end else begin
            stop <= 1'b0;
          end
        end
        ST_HIT: begin
          if (bus.Ack) begin
            state <= ST_IDLE;
            stop  <= 1'b0;
          end else begin
            stop <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          stop  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Stop    = stop;
  assign bus.Gap_Top = gap_top;
  assign bus.Gap_Bot = gap_bot;
  assign bus.Q_Idle  = state[0];
  assign bus.Q_Armed = state[1];
  assign bus.Q_Hit   = state[2];

endmodule

// File: tb/tb_pipe_collision_checker.sv
// Bench for pipe_collision_checker: vector table, directed corner sequences and a
// randomized run against a history-based model of the game rules.
module tb_pipe_collision_checker;

  logic clk;
  logic reset;

  pipe_collision_checker_if bus ();

  pipe_collision_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  int gap_tbl [5] = '{120, 200, 80, 260, 160};

  typedef struct {
    logic [2:0] idx;
    logic [9:0] xl;
    logic [9:0] xr;
    logic [9:0] y;
    logic       stop;
    logic [9:0] gt;
    logic [9:0] gb;
  } vec_t;

  typedef struct {
    bit acc;
    bit cond;
  } hist_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic run, input logic ack, input logic [2:0] idx,
                                input logic [9:0] xl, input logic [9:0] xr, input logic [9:0] y);
    bus.Run      = run;
    bus.Ack      = ack;
    bus.Pipe_Idx = idx;
    bus.X_Edge_L = xl;
    bus.X_Edge_R = xr;
    bus.Bird_Y   = y;
  endtask

  task automatic check_state(input string tag, input int stop, input int idle, input int armed, input int hitq);
    check_output({tag, "_stop"},  int'(bus.Stop),    stop);
    check_output({tag, "_idle"},  int'(bus.Q_Idle),  idle);
    check_output({tag, "_armed"}, int'(bus.Q_Armed), armed);
    check_output({tag, "_hit"},   int'(bus.Q_Hit),   hitq);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 3'd7, 10'd500, 10'd560, 10'd100);
    tick();
    reset = 1'b0;
  endtask

  task automatic arm();
    apply_stimulus(1'b1, 1'b0, 3'd7, 10'd500, 10'd560, 10'd100);
    tick();
  endtask

  function automatic bit hit_rule(int idx, int xl, int xr, int y);
    int  gt;
    bit  pipe;
    bit  bnd;
    bnd  = (y == 0) || (y + 20 >= 480);
    pipe = 1'b0;
    if (idx < 5) begin
      gt   = gap_tbl[idx];
      pipe = (xl <= 230) && (xr >= 200) && ((y < gt) || (y + 20 > gt + 140));
    end
    return bnd || pipe;
  endfunction

  vec_t  vecs [13];
  hist_t hist [$];

  initial begin
    int    mstate;
    int    prev_idx;
    int    exp_gt;
    int    exp_gb;
    int    r_run, r_ack, r_idx, r_xl, r_xr, r_y;
    bit    mhit;
    hist_t rec;

    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 3'd0, 10'd0, 10'd0, 10'd100);

    vecs[0]  = '{3'd2, 10'd190, 10'd251, 10'd100, 1'b0, 10'd80,  10'd220};
    vecs[1]  = '{3'd2, 10'd190, 10'd251, 10'd70,  1'b1, 10'd80,  10'd220};
    vecs[2]  = '{3'd0, 10'd231, 10'd292, 10'd10,  1'b0, 10'd120, 10'd260};
    vecs[3]  = '{3'd0, 10'd230, 10'd292, 10'd10,  1'b1, 10'd120, 10'd260};
    vecs[4]  = '{3'd0, 10'd100, 10'd199, 10'd10,  1'b0, 10'd120, 10'd260};
    vecs[5]  = '{3'd0, 10'd100, 10'd200, 10'd10,  1'b1, 10'd120, 10'd260};
    vecs[6]  = '{3'd6, 10'd190, 10'd251, 10'd460, 1'b1, 10'd0,   10'd0};
    vecs[7]  = '{3'd6, 10'd190, 10'd251, 10'd459, 1'b0, 10'd0,   10'd0};
    vecs[8]  = '{3'd1, 10'd400, 10'd460, 10'd0,   1'b1, 10'd200, 10'd340};
    vecs[9]  = '{3'd3, 10'd190, 10'd251, 10'd380, 1'b0, 10'd260, 10'd400};
    vecs[10] = '{3'd3, 10'd190, 10'd251, 10'd381, 1'b1, 10'd260, 10'd400};
    vecs[11] = '{3'd4, 10'd190, 10'd251, 10'd160, 1'b0, 10'd160, 10'd300};
    vecs[12] = '{3'd4, 10'd190, 10'd251, 10'd159, 1'b1, 10'd160, 10'd300};

    tick();
    reset_dut();
    check_state("reset", 0, 1, 0, 0);
    check_output("reset_gap_top", int'(bus.Gap_Top), 0);
    check_output("reset_gap_bot", int'(bus.Gap_Bot), 0);

    // Each vector starts from a fresh armed state and is held until Stop is due.
    for (int i = 0; i < 13; i++) begin
      reset_dut();
      arm();
      apply_stimulus(1'b1, 1'b0, vecs[i].idx, vecs[i].xl, vecs[i].xr, vecs[i].y);
      tick();
      tick();
      tick();
      check_output($sformatf("vec%0d_stop", i),    int'(bus.Stop),    int'(vecs[i].stop));
      check_output($sformatf("vec%0d_qhit", i),    int'(bus.Q_Hit),   int'(vecs[i].stop));
      check_output($sformatf("vec%0d_gap_top", i), int'(bus.Gap_Top), int'(vecs[i].gt));
      check_output($sformatf("vec%0d_gap_bot", i), int'(bus.Gap_Bot), int'(vecs[i].gb));
    end

    // Gap latency, Stop latency, Stop held as a level, Ack release.
    reset_dut();
    apply_stimulus(1'b1, 1'b0, 3'd2, 10'd190, 10'd251, 10'd100);
    tick();
    check_state("seqA_armed", 0, 0, 1, 0);
    check_output("seqA_gap_top_early", int'(bus.Gap_Top), 0);
    tick();
    check_output("seqA_gap_top", int'(bus.Gap_Top), 80);
    check_output("seqA_gap_bot", int'(bus.Gap_Bot), 220);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state("seqA_clear", 0, 0, 1, 0);
    end
    apply_stimulus(1'b1, 1'b0, 3'd2, 10'd190, 10'd251, 10'd70);
    tick();
    check_output("seqA_stop_n", int'(bus.Stop), 0);
    tick();
    check_output("seqA_stop_n1", int'(bus.Stop), 0);
    tick();
    check_state("seqA_stop_n2", 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("seqA_stop_held", int'(bus.Stop), 1);
    end
    apply_stimulus(1'b1, 1'b1, 3'd2, 10'd190, 10'd251, 10'd70);
    tick();
    check_state("seqA_ack", 0, 1, 0, 0);

    // Run drops while a hit sits only in stage 1: it must be discarded.
    reset_dut();
    arm();
    apply_stimulus(1'b1, 1'b0, 3'd2, 10'd190, 10'd251, 10'd100);
    tick();
    tick();
    tick();
    apply_stimulus(1'b0, 1'b0, 3'd2, 10'd190, 10'd251, 10'd70);
    tick();
    check_state("seqB_drop", 0, 1, 0, 0);
    tick();
    tick();
    check_state("seqB_idle", 0, 1, 0, 0);

    // Run drops while the hit is already in stage 2: the hit wins.
    reset_dut();
    arm();
    apply_stimulus(1'b1, 1'b0, 3'd2, 10'd190, 10'd251, 10'd70);
    tick();
    tick();
    apply_stimulus(1'b0, 1'b0, 3'd2, 10'd190, 10'd251, 10'd70);
    tick();
    check_state("seqC_hit", 1, 0, 0, 1);

    // Reset out of HIT, then re-arm on a clean position.
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b0, 3'd2, 10'd190, 10'd251, 10'd70);
    tick();
    reset = 1'b0;
    check_state("seqD_reset", 0, 1, 0, 0);
    check_output("seqD_gap_top", int'(bus.Gap_Top), 0);
    check_output("seqD_gap_bot", int'(bus.Gap_Bot), 0);
    apply_stimulus(1'b1, 1'b0, 3'd2, 10'd190, 10'd251, 10'd100);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_state("seqD_rearm", 0, 0, 1, 0);
    end

    // Ack alongside a fresh hit goes to IDLE; re-arming refills the pipe first.
    apply_stimulus(1'b1, 1'b0, 3'd2, 10'd190, 10'd251, 10'd70);
    tick();
    tick();
    tick();
    check_output("seqE_stop", int'(bus.Stop), 1);
    apply_stimulus(1'b1, 1'b1, 3'd2, 10'd190, 10'd251, 10'd70);
    tick();
    check_state("seqE_ack", 0, 1, 0, 0);
    apply_stimulus(1'b1, 1'b0, 3'd2, 10'd190, 10'd251, 10'd70);
    tick();
    check_state("seqE_rearm", 0, 0, 1, 0);
    tick();
    check_output("seqE_fill1", int'(bus.Stop), 0);
    tick();
    check_output("seqE_fill2", int'(bus.Stop), 0);
    tick();
    check_state("seqE_rehit", 1, 0, 0, 1);

    // Randomized run: the model looks back two edges in an input history queue.
    reset_dut();
    mstate   = 0;
    prev_idx = 7;
    exp_gt   = 0;
    exp_gb   = 0;
    hist.delete();
    for (int t = 0; t < 3000; t++) begin
      r_run = ($urandom_range(0, 15) != 0) ? 1 : 0;
      if (mstate == 2) r_ack = ($urandom_range(0, 3) == 0) ? 1 : 0;
      else             r_ack = ($urandom_range(0, 7) == 0) ? 1 : 0;
      r_idx = int'($urandom_range(0, 7));
      r_xl  = int'($urandom_range(150, 260));
      r_xr  = r_xl + int'($urandom_range(0, 80));
      case ($urandom_range(0, 7))
        0:       r_y = 0;
        1:       r_y = int'($urandom_range(455, 465));
        2:       r_y = int'($urandom_range(1000, 1023));
        default: r_y = int'($urandom_range(1, 479));
      endcase
      apply_stimulus(r_run[0], r_ack[0], 3'(r_idx), 10'(r_xl), 10'(r_xr), 10'(r_y));

      mhit = 1'b0;
      if (hist.size() >= 2)
        mhit = hist[hist.size()-2].acc && hist[hist.size()-1].acc && hist[hist.size()-2].cond;
      rec.acc  = (r_run == 1) && (mstate == 1);
      rec.cond = hit_rule(r_idx, r_xl, r_xr, r_y);
      hist.push_back(rec);
      if (hist.size() > 2) void'(hist.pop_front());

      if (prev_idx < 5) begin
        exp_gt = gap_tbl[prev_idx];
        exp_gb = exp_gt + 140;
      end
      prev_idx = r_idx;

      case (mstate)
        0: if (r_run == 1) mstate = 1;
        1: begin
          if (mhit)             mstate = 2;
          else if (r_run == 0)  mstate = 0;
        end
        default: if (r_ack == 1) mstate = 0;
      endcase

      tick();
      check_state($sformatf("rand%0d", t), (mstate == 2) ? 1 : 0, (mstate == 0) ? 1 : 0,
                  (mstate == 1) ? 1 : 0, (mstate == 2) ? 1 : 0);
      check_output($sformatf("rand%0d_gap_top", t), int'(bus.Gap_Top), exp_gt);
      check_output($sformatf("rand%0d_gap_bot", t), int'(bus.Gap_Bot), exp_gb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_collision_checker.md
Name: pipe_collision_checker

Overview:
- Consumer of the pipe X-coordinate generator. Takes the in-scope pipe's left/right edges and index, looks up that pipe's gap Y from a fixed table, and compares the bird box against the pipe, ceiling and floor.
- On a hit it raises Stop to the generator and holds it until Ack. Also exports the registered gap bounds for the renderer.

Parameters:
- BIRD_X_L, 200, bird left edge (pixels)
- BIRD_X_R, 230, bird right edge (pixels)
- BIRD_H, 20, bird height (pixels)
- GAP_H, 140, vertical gap opening per pipe (pixels)
- SCREEN_H, 480, floor Y (pixels)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Run  in  1  generator counting-state flag (Q_Count)
- Ack  in  1  game-over acknowledge
- Pipe_Idx  in  3  index of the in-scope pipe (out_pipe)
- X_Edge_L  in  10  in-scope pipe left edge
- X_Edge_R  in  10  in-scope pipe right edge
- Bird_Y  in  10  bird top edge
- Stop  out  1  collision/game-over level to the generator
- Gap_Top  out  10  registered gap top of the in-scope pipe
- Gap_Bot  out  10  registered gap bottom (Gap_Top+GAP_H)
- Q_Idle, Q_Armed, Q_Hit  out  1 each  one-hot state flags

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, Stop=0, Gap_Top=0, Gap_Bot=0, all pipeline valid bits=0.
- Stage 1 (cycle N): register Pipe_Idx, X_Edge_L, X_Edge_R and Bird_Y. The gap ROM is read with the registered index (synchronous ROM).
- Stage 2 (N+1): register gap_top, gap_bot, x_overlap, y_out and idx_valid.
- Stage 3 (N+2): update the FSM. Stop is visible at N+2 for a hit condition present at cycle N.
- v1/v2 valid bits:
  - Set only while Run=1 and the state is ARMED.
  - Cleared on reset, on entering ARMED, and whenever Run=0.
  - Stale data is never evaluated.
- Gap table (index 0..4): 120, 200, 80, 260, 160.
  - Index 5..7 means no pipe: idx_valid=0, no pipe hit. Ceiling and floor checks still apply.
  - Gap_Top and Gap_Bot hold their last values for index 5..7.
- Arithmetic:
  - Bird bottom = Bird_Y+BIRD_H, computed 11-bit with no wrap.
  - Gap_Bot = gap_top+GAP_H. All table entries are below SCREEN_H-GAP_H.
- Hit conditions:
  - x_overlap = (X_Edge_L <= BIRD_X_R) && (X_Edge_R >= BIRD_X_L). Both comparisons are inclusive.
  - y_out = (Bird_Y < gap_top) || (Bird_Y+BIRD_H > gap_bot).
  - pipe_hit = idx_valid && x_overlap && y_out.
  - bound_hit = (Bird_Y == 0) || (Bird_Y+BIRD_H >= SCREEN_H).
  - hit = v2 && (pipe_hit || bound_hit).
- FSM (one-hot, 3 bits):
  - IDLE: Stop=0. Run=1 -> ARMED.
  - ARMED: Stop=0. hit -> HIT. Else Run=0 -> IDLE. Ack is ignored.
  - HIT: Stop=1. Ack=1 -> IDLE, with Stop=0 in the next cycle. Run is ignored, since the generator leaves counting one cycle after Stop.
  - Illegal encoding -> IDLE.
- Simultaneous events:
  - In ARMED, hit has priority over Run falling.
  - In HIT, Ack with a new hit returns to IDLE. Re-arming needs Run to be seen again.
- Reset mid-game: the next cycle is IDLE, Stop=0 and the pipeline is flushed. This is independent of Run and Ack.
- Stop is a level, not a pulse. It is asserted for every cycle spent in HIT.

Decomposition:
- Shared package (flappy_pkg):
  - State one-hot encodings: IDLE=3'b001, ARMED=3'b010, HIT=3'b100.
  - Constants SCREEN_H=480 and SCREEN_W=640, and the pipe count 5.
  - The gap-table values, so the renderer can share them.
- Sub-module: pipe_gap_rom. 5-entry synchronous ROM; 3-bit address in; 10-bit gap_top out; 1-bit valid out.

Test Plan:
- Reset, then Run=1, Pipe_Idx=2 (gap 80..220), X_L=190, X_R=251, Bird_Y=100 -> no hit. Stop=0 and Q_Armed=1 indefinitely; Gap_Top=80 and Gap_Bot=220 two cycles after the inputs.
- Same setup, Bird_Y changes to 70 at cycle N -> Stop=1 at N+2. Stop is held 10 cycles with Ack=0, then Ack=1 gives Stop=0 and Q_Idle=1 the next cycle.
- Pipe_Idx=0 (gap 120..260), X_L=231, X_R=292, Bird_Y=10 -> no hit (no X overlap). X_L=230 -> hit 2 cycles later (inclusive edge).
- Run=1, Pipe_Idx=6, Bird_Y=460 -> bound hit (460+20=480), so Stop=1. Bird_Y=459 with Pipe_Idx=6 -> no hit, and Gap_Top keeps its previous value.
- In ARMED with a hit condition presented, Run drops in the same cycle -> stage-1 data is discarded (v cleared), so the result is IDLE and Stop stays 0. A separate case: hit already in stage 2 when Run drops -> HIT.
- Stop=1 in HIT, then reset=1 for one cycle -> next cycle Stop=0, Q_Idle=1, Gap_Top=0. Run=1 with a clean pipe position -> ARMED with no spurious Stop.
